// File: rtl/lifo_pkg.sv
// Shared definitions for the LIFO stack: default geometry, operation encoding
// and the stack-pointer width helper.
package lifo_pkg;

   localparam int LIFO_WIDTH_DEF = 8;
   localparam int LIFO_DEPTH_DEF = 8;

   // Resolved per-cycle stack operation after push/pop arbitration.
   typedef enum logic [1:0] {
      LIFO_OP_IDLE = 2'b00,
      LIFO_OP_PUSH = 2'b01,
      LIFO_OP_POP  = 2'b10
   } lifo_op_e;

   // The pointer counts occupancy 0..DEPTH inclusive, hence DEPTH+1 states.
   function automatic int lifo_ptr_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int lifo_addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage : lifo_pkg

// File: rtl/lifo_mem.sv
// DEPTH x WIDTH register array with one synchronous write port and one
// asynchronous read port; contents are intentionally never reset.
module lifo_mem
   import lifo_pkg::*;
#(
   parameter int WIDTH = LIFO_WIDTH_DEF,
   parameter int DEPTH = LIFO_DEPTH_DEF,
   parameter int AW    = lifo_addr_width(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Storage write on the rising edge when enabled.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Combinational read of the addressed entry.
   always_comb begin
      o_rdata = r_mem[i_raddr];
   end

endmodule : lifo_mem

// File: rtl/lifo_stack.sv
// Synchronous LIFO stack: stack pointer, push/pop arbitration (pop wins),
// registered pop data and occupancy flags derived from the pointer.
module lifo_stack
   import lifo_pkg::*;
#(
   parameter int WIDTH = LIFO_WIDTH_DEF,
   parameter int DEPTH = LIFO_DEPTH_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wn,
   input  logic             rn,
   input  logic [WIDTH-1:0] DATAIN,
   output logic [WIDTH-1:0] DATAOUT,
   output logic             full,
   output logic             empty
);

   localparam int PW = lifo_ptr_width(DEPTH);
   localparam int AW = lifo_addr_width(DEPTH);
   localparam logic [PW-1:0] SP_FULL = PW'(DEPTH);

   logic [PW-1:0]    r_sp;
   logic [WIDTH-1:0] r_dataout;
   lifo_op_e         w_op;
   logic             w_full;
   logic             w_empty;
   logic             w_we;
   logic [AW-1:0]    w_waddr;
   logic [AW-1:0]    w_raddr;
   logic [WIDTH-1:0] w_rdata;

   // Occupancy flags straight from the pointer.
   always_comb begin
      w_full  = (r_sp == SP_FULL);
      w_empty = (r_sp == {PW{1'b0}});
   end

   // A pop request always shadows a concurrent push, even when the pop itself is refused.
   always_comb begin
      w_op = LIFO_OP_IDLE;
      if (rn) begin
         if (!w_empty) begin
            w_op = LIFO_OP_POP;
         end else begin
            w_op = LIFO_OP_IDLE;
         end
      end else if (wn && !w_full) begin
         w_op = LIFO_OP_PUSH;
      end else begin
         w_op = LIFO_OP_IDLE;
      end
   end

   // Modular low-bit arithmetic gives sp-1 correctly because sp never exceeds 2**AW.
   always_comb begin
      w_we    = (w_op == LIFO_OP_PUSH) && reset;
      w_waddr = r_sp[AW-1:0];
      w_raddr = r_sp[AW-1:0] - AW'(1);
   end

   lifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .i_clk   (clock),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (DATAIN),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   // Pointer and output register; reset discards every stored word.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_sp      <= {PW{1'b0}};
         r_dataout <= {WIDTH{1'b0}};
      end else begin
         case (w_op)
            LIFO_OP_PUSH: begin
               r_sp <= r_sp + PW'(1);
            end
            LIFO_OP_POP: begin
               r_sp      <= r_sp - PW'(1);
               r_dataout <= w_rdata;
            end
            default: begin
               r_sp      <= r_sp;
               r_dataout <= r_dataout;
            end
         endcase
      end
   end

   assign DATAOUT = r_dataout;
   assign full    = w_full;
   assign empty   = w_empty;

endmodule : lifo_stack

// File: tb/tb_lifo_stack.sv
// Directed self-checking bench for lifo_stack (WIDTH=8, DEPTH=8).
module tb_lifo_stack;

   localparam int WIDTH = 8;
   localparam int DEPTH = 8;

   logic             clock;
   logic             reset;
   logic             wn;
   logic             rn;
   logic [WIDTH-1:0] DATAIN;
   logic [WIDTH-1:0] DATAOUT;
   logic             full;
   logic             empty;

   int checks;
   int errors;

   lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clock   (clock),
      .reset   (reset),
      .wn      (wn),
      .rn      (rn),
      .DATAIN  (DATAIN),
      .DATAOUT (DATAOUT),
      .full    (full),
      .empty   (empty)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_push(input logic [WIDTH-1:0] d);
      wn = 1'b1; rn = 1'b0; DATAIN = d;
      tick();
      wn = 1'b0;
   endtask

   task automatic do_pop();
      wn = 1'b0; rn = 1'b1;
      tick();
      rn = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; wn = 1'b0; rn = 1'b0; DATAIN = 8'd0;
      tick();
      reset = 1'b1;
      checks++; if (DATAOUT !== 8'd0) begin errors++; $display("FAIL reset_dataout got %0d exp 0", DATAOUT); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
   endtask

   task automatic test_lifo_order();
      logic [WIDTH-1:0] exp_v [3];
      exp_v[0] = 8'd200; exp_v[1] = 8'd150; exp_v[2] = 8'd100;
      do_push(8'd100);
      do_push(8'd150);
      do_push(8'd200);
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL order_not_empty got %b exp 0", empty); end
      for (int i = 0; i < 3; i++) begin
         do_pop();
         checks++;
         if (DATAOUT !== exp_v[i]) begin errors++; $display("FAIL order_pop%0d got %0d exp %0d", i, DATAOUT, exp_v[i]); end
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL order_empty got %b exp 1", empty); end
   endtask

   task automatic test_underflow();
      for (int i = 0; i < 2; i++) begin
         do_pop();
         checks++; if (DATAOUT !== 8'd100) begin errors++; $display("FAIL underflow_data%0d got %0d exp 100", i, DATAOUT); end
         checks++; if (empty !== 1'b1) begin errors++; $display("FAIL underflow_empty%0d got %b exp 1", i, empty); end
      end
   endtask

   task automatic test_full_overflow();
      for (int i = 1; i <= DEPTH; i++) begin
         do_push(WIDTH'(i));
      end
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", full); end
      do_push(8'd99);
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL overflow_full got %b exp 1", full); end
      checks++; if (DATAOUT !== 8'd100) begin errors++; $display("FAIL overflow_dataout got %0d exp 100", DATAOUT); end
      do_pop();
      checks++; if (DATAOUT !== 8'd8) begin errors++; $display("FAIL full_pop got %0d exp 8", DATAOUT); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_cleared got %b exp 0", full); end
      // Drain with back-to-back pops; the ignored 99 must not appear anywhere.
      for (int i = 7; i >= 1; i--) begin
         do_pop();
         checks++;
         if (DATAOUT !== WIDTH'(i)) begin errors++; $display("FAIL drain_pop got %0d exp %0d", DATAOUT, i); end
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", empty); end
   endtask

   task automatic test_simultaneous();
      do_push(8'd10);
      do_push(8'd20);
      wn = 1'b1; rn = 1'b1; DATAIN = 8'd77;
      tick();
      wn = 1'b0; rn = 1'b0;
      checks++; if (DATAOUT !== 8'd20) begin errors++; $display("FAIL simul_dataout got %0d exp 20", DATAOUT); end
      checks++; if (dut.r_sp !== 4'd1) begin errors++; $display("FAIL simul_sp got %0d exp 1", dut.r_sp); end
      do_pop();
      checks++; if (DATAOUT !== 8'd10) begin errors++; $display("FAIL simul_pop got %0d exp 10", DATAOUT); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL simul_empty got %b exp 1", empty); end
   endtask

   task automatic test_hold();
      do_push(8'd33);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (DATAOUT !== 8'd10 || empty !== 1'b0) begin
            errors++; $display("FAIL hold%0d got %0d/%b exp 10/0", i, DATAOUT, empty);
         end
      end
      do_pop();
      checks++; if (DATAOUT !== 8'd33) begin errors++; $display("FAIL hold_pop got %0d exp 33", DATAOUT); end
   endtask

   task automatic test_reset_mid();
      do_push(8'd5);
      do_push(8'd6);
      reset = 1'b0; wn = 1'b1; DATAIN = 8'd9;
      tick();
      reset = 1'b1; wn = 1'b0;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midrst_empty got %b exp 1", empty); end
      checks++; if (DATAOUT !== 8'd0) begin errors++; $display("FAIL midrst_dataout got %0d exp 0", DATAOUT); end
      do_pop();
      checks++; if (DATAOUT !== 8'd0) begin errors++; $display("FAIL midrst_pop got %0d exp 0", DATAOUT); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midrst_pop_empty got %b exp 1", empty); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_lifo_order();
      test_underflow();
      test_full_overflow();
      test_simultaneous();
      test_hold();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_lifo_stack
